// File: rtl/fcl1_pkg.sv
// Shared types and sizing constants for the FC-layer-1 MAC sequencer.
package fcl1_pkg;

  localparam int GROUP_SIZE = 5;
  localparam int MAX_IN     = 400;
  localparam int MAX_OUT    = 120;
  localparam int MAX_GRP    = MAX_IN / GROUP_SIZE + 1;

  localparam int NUM_IN_W   = $clog2(MAX_IN + 1);
  localparam int NUM_OUT_W  = $clog2(MAX_OUT + 1);
  localparam int ACT_ADDR_W = $clog2(MAX_GRP);
  localparam int WGT_ADDR_W = $clog2(MAX_OUT * MAX_GRP);
  localparam int IDX_W      = $clog2(MAX_OUT);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    OUT,
    FIN
  } state_e;

endpackage

// File: rtl/fcl1_grp_mask.sv
// Splits one buffer read into five activation/weight pairs, zeroing lanes
// beyond the remaining element count of the neuron.
module fcl1_grp_mask
  import fcl1_pkg::*;
#(
  parameter int OPERAND_WIDTH = 8
) (
  input  logic [NUM_IN_W-1:0]                              rem_cnt,
  input  logic [GROUP_SIZE*OPERAND_WIDTH-1:0]              act_rdata,
  input  logic [GROUP_SIZE*OPERAND_WIDTH-1:0]              wgt_rdata,
  output logic [GROUP_SIZE-1:0][1:0][OPERAND_WIDTH-1:0]    pairs
);

  always_comb begin
    // NOTE: assign a default before any conditional write so no latch is inferred.
    pairs = '0;
    for (int k = 0; k < GROUP_SIZE; k++) begin
      if (rem_cnt > NUM_IN_W'(k)) begin
        pairs[k][0] = act_rdata[k*OPERAND_WIDTH +: OPERAND_WIDTH];
        pairs[k][1] = wgt_rdata[k*OPERAND_WIDTH +: OPERAND_WIDTH];
      end
    end
  end

endmodule

// File: rtl/fcl1_mac_sched.sv
// FC-layer-1 sequencer: streams 5-element groups into mult_add_5pairs,
// accumulates per neuron, returns results over valid/ready.
// Optional macro FCL1_SCHED_BIAS_EN seeds each neuron's accumulator with a bias.
module fcl1_mac_sched
  import fcl1_pkg::*;
#(
  parameter int OPERAND_WIDTH = 8,
  parameter int MAC_LAT       = 2,
  parameter int ACC_WIDTH     = 32
) (
  input  logic                               fcl_sched_clk,
  input  logic                               fcl_sched_rst_b,
  input  logic                               start_i,
  input  logic [NUM_IN_W-1:0]                num_in_i,
  input  logic [NUM_OUT_W-1:0]               num_out_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic [ACT_ADDR_W-1:0]              act_addr_o,
  output logic [WGT_ADDR_W-1:0]              wgt_addr_o,
  output logic                               rd_en_o,
  input  logic [GROUP_SIZE*OPERAND_WIDTH-1:0] act_rdata_i,
  input  logic [GROUP_SIZE*OPERAND_WIDTH-1:0] wgt_rdata_i,
  output logic [1:0][OPERAND_WIDTH-1:0]      op_a_o,
  output logic [1:0][OPERAND_WIDTH-1:0]      op_b_o,
  output logic [1:0][OPERAND_WIDTH-1:0]      op_c_o,
  output logic [1:0][OPERAND_WIDTH-1:0]      op_d_o,
  output logic [1:0][OPERAND_WIDTH-1:0]      op_e_o,
  input  logic [2*OPERAND_WIDTH+2:0]         dp_sum_i,
`ifdef FCL1_SCHED_BIAS_EN
  input  logic [OPERAND_WIDTH-1:0]           bias_rdata_i,
  output logic [IDX_W-1:0]                   bias_addr_o,
`endif
  output logic                               res_valid_o,
  input  logic                               res_ready_i,
  output logic [ACC_WIDTH-1:0]               res_data_o,
  output logic [IDX_W-1:0]                   res_idx_o
);

  // Read -> rdata -> registered operands -> MAC_LAT datapath stages.
  localparam int PIPE_D = 2 + MAC_LAT;

  state_e                                          state;
  logic [NUM_IN_W-1:0]                             num_in_q;
  logic [NUM_OUT_W-1:0]                            num_out_q;
  logic [NUM_IN_W-1:0]                             rem_cnt;
  logic [NUM_IN_W-1:0]                             mask_rem;
  logic [PIPE_D-1:0]                               vld_sr;
  logic [ACC_WIDTH-1:0]                            acc;
  logic [GROUP_SIZE-1:0][1:0][OPERAND_WIDTH-1:0]   pairs;
  logic [GROUP_SIZE-1:0][1:0][OPERAND_WIDTH-1:0]   op_q;
  logic                                            last_grp;
  logic                                            last_idx;
`ifdef FCL1_SCHED_BIAS_EN
  logic                                            first_q;

  assign bias_addr_o = res_idx_o;
`endif

  assign last_grp = (rem_cnt <= NUM_IN_W'(GROUP_SIZE));
  assign last_idx = (res_idx_o == IDX_W'(num_out_q - NUM_OUT_W'(1)));

  fcl1_grp_mask #(
    .OPERAND_WIDTH (OPERAND_WIDTH)
  ) u_grp_mask (
    .rem_cnt   (mask_rem),
    .act_rdata (act_rdata_i),
    .wgt_rdata (wgt_rdata_i),
    .pairs     (pairs)
  );

  assign op_a_o = op_q[0];
  assign op_b_o = op_q[1];
  assign op_c_o = op_q[2];
  assign op_d_o = op_q[3];
  assign op_e_o = op_q[4];

  // mask_rem is zero in cycles with no read in flight, which forces the
  // operands back to zero whatever the buffers present.
  always_ff @(posedge fcl_sched_clk or negedge fcl_sched_rst_b) begin
    if (!fcl_sched_rst_b) begin
      mask_rem <= '0;
      op_q     <= '0;
      vld_sr   <= '0;
    end else begin
      mask_rem <= rd_en_o ? rem_cnt : '0;
      op_q     <= pairs;
      vld_sr   <= {vld_sr[PIPE_D-2:0], rd_en_o};
    end
  end

  always_ff @(posedge fcl_sched_clk or negedge fcl_sched_rst_b) begin
    if (!fcl_sched_rst_b) begin
      state       <= IDLE;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      rd_en_o     <= 1'b0;
      act_addr_o  <= '0;
      wgt_addr_o  <= '0;
      res_valid_o <= 1'b0;
      res_data_o  <= '0;
      res_idx_o   <= '0;
      num_in_q    <= '0;
      num_out_q   <= '0;
      rem_cnt     <= '0;
      acc         <= '0;
`ifdef FCL1_SCHED_BIAS_EN
      first_q     <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // right-hand side below sees the pre-edge value.
      done_o <= 1'b0;
      if (vld_sr[PIPE_D-1]) begin
        acc <= acc + ACC_WIDTH'(dp_sum_i);
      end

      case (state)
        IDLE: begin
          if (start_i) begin
            num_in_q   <= num_in_i;
            num_out_q  <= num_out_i;
            busy_o     <= 1'b1;
            res_idx_o  <= '0;
            wgt_addr_o <= '0;
            act_addr_o <= '0;
            acc        <= '0;
            if (num_out_i == '0) begin
              state <= FIN;
            end else begin
              state   <= ISSUE;
              rd_en_o <= (num_in_i != '0);
              rem_cnt <= num_in_i;
`ifdef FCL1_SCHED_BIAS_EN
              first_q <= 1'b1;
`endif
            end
          end
        end

        ISSUE: begin
`ifdef FCL1_SCHED_BIAS_EN
          first_q <= 1'b0;
          if (first_q) begin
            acc <= ACC_WIDTH'(bias_rdata_i);
          end
`endif
          if (rd_en_o) begin
            wgt_addr_o <= wgt_addr_o + WGT_ADDR_W'(1);
          end
          if (rd_en_o && !last_grp) begin
            act_addr_o <= act_addr_o + ACT_ADDR_W'(1);
            rem_cnt    <= rem_cnt - NUM_IN_W'(GROUP_SIZE);
          end else begin
            rd_en_o <= 1'b0;
            state   <= DRAIN;
          end
        end

        DRAIN: begin
          if (vld_sr == '0) begin
            res_data_o  <= acc;
            res_valid_o <= 1'b1;
            state       <= OUT;
          end
        end

        OUT: begin
          if (res_ready_i) begin
            res_valid_o <= 1'b0;
            if (last_idx) begin
              state <= FIN;
            end else begin
              res_idx_o  <= res_idx_o + IDX_W'(1);
              acc        <= '0;
              act_addr_o <= '0;
              rem_cnt    <= num_in_q;
              rd_en_o    <= (num_in_q != '0);
              state      <= ISSUE;
`ifdef FCL1_SCHED_BIAS_EN
              first_q    <= 1'b1;
`endif
            end
          end
        end

        FIN: begin
          busy_o <= 1'b0;
          done_o <= 1'b1;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fcl1_mac_sched.sv
// Directed bench for fcl1_mac_sched with a behavioural buffer/datapath model
// and a per-cycle compare process.
module tb_fcl1_mac_sched;
  import fcl1_pkg::*;

  localparam int W       = 8;
  localparam int MAC_LAT = 2;
  localparam int ACC_W   = 32;
  localparam int SUM_W   = 2*W + 3;
  localparam logic [W-1:0] BIAS_BYTE = 8'h10;
`ifdef FCL1_SCHED_BIAS_EN
  localparam int BIAS_TERM = 16;
`else
  localparam int BIAS_TERM = 0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_b = 1'b0;
  logic                  start = 1'b0;
  logic [NUM_IN_W-1:0]   num_in = '0;
  logic [NUM_OUT_W-1:0]  num_out = '0;
  logic                  busy, done, rd_en;
  logic [ACT_ADDR_W-1:0] act_addr;
  logic [WGT_ADDR_W-1:0] wgt_addr;
  logic [5*W-1:0]        act_rdata = '0;
  logic [5*W-1:0]        wgt_rdata = '0;
  logic [1:0][W-1:0]     op_a, op_b, op_c, op_d, op_e;
  logic [SUM_W-1:0]      dp_sum;
  logic                  res_valid;
  logic                  res_ready = 1'b0;
  logic [ACC_W-1:0]      res_data;
  logic [IDX_W-1:0]      res_idx;
`ifdef FCL1_SCHED_BIAS_EN
  logic [W-1:0]          bias_rdata;
  logic [IDX_W-1:0]      bias_addr;
  assign bias_rdata = BIAS_BYTE;
`endif

  fcl1_mac_sched #(.OPERAND_WIDTH(W), .MAC_LAT(MAC_LAT), .ACC_WIDTH(ACC_W)) dut (
    .fcl_sched_clk   (clk),
    .fcl_sched_rst_b (rst_b),
    .start_i         (start),
    .num_in_i        (num_in),
    .num_out_i       (num_out),
    .busy_o          (busy),
    .done_o          (done),
    .act_addr_o      (act_addr),
    .wgt_addr_o      (wgt_addr),
    .rd_en_o         (rd_en),
    .act_rdata_i     (act_rdata),
    .wgt_rdata_i     (wgt_rdata),
    .op_a_o          (op_a),
    .op_b_o          (op_b),
    .op_c_o          (op_c),
    .op_d_o          (op_d),
    .op_e_o          (op_e),
    .dp_sum_i        (dp_sum),
`ifdef FCL1_SCHED_BIAS_EN
    .bias_rdata_i    (bias_rdata),
    .bias_addr_o     (bias_addr),
`endif
    .res_valid_o     (res_valid),
    .res_ready_i     (res_ready),
    .res_data_o      (res_data),
    .res_idx_o       (res_idx)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Job under test as the model sees it.
  int        cur_num_in  = 0;
  int        cur_num_out = 0;
  logic [7:0] act_byte   = 8'h00;
  logic [7:0] wgt_byte   = 8'h00;

  // Buffers: constant fill when read, junk otherwise.
  always @(posedge clk) begin
    act_rdata <= rd_en ? {5{act_byte}} : '1;
    wgt_rdata <= rd_en ? {5{wgt_byte}} : '1;
  end

  // Datapath: sum of the five products, MAC_LAT register stages.
  function automatic int prod(input logic [1:0][W-1:0] p);
    return int'(p[0]) * int'(p[1]);
  endfunction

  logic [SUM_W-1:0] dp_pipe [MAC_LAT];
  always @(posedge clk) begin
    dp_pipe[0] <= SUM_W'(prod(op_a) + prod(op_b) + prod(op_c) + prod(op_d) + prod(op_e));
    for (int i = 1; i < MAC_LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign dp_sum = dp_pipe[MAC_LAT-1];

  function automatic logic [ACC_W-1:0] model_res();
    return ACC_W'(cur_num_in * int'(act_byte) * int'(wgt_byte) + BIAS_TERM);
  endfunction

  // Compare process state.
  logic             h_rd [2];
  int               h_g  [2];
  int               exp_idx = 0, acc_cnt = 0, rd_cnt = 0, done_cnt = 0;
  int               rd_in_neuron = 0, wgt_exp = 0;
  logic             prev_stall = 1'b0;
  logic [ACC_W-1:0] prev_data;
  logic [IDX_W-1:0] prev_idx;
  int               wgt_log [$];
  logic [ACC_W-1:0] res_log [$];

  always @(negedge clk) begin
    if (!rst_b) begin
      h_rd[0] = 1'b0; h_rd[1] = 1'b0; h_g[0] = 0; h_g[1] = 0;
      exp_idx = 0; acc_cnt = 0; rd_cnt = 0; rd_in_neuron = 0; wgt_exp = 0;
      prev_stall = 1'b0;
    end else begin
      logic [4:0][1:0][7:0] e;
      logic live;
      for (int k = 0; k < 5; k++) begin
        live = h_rd[1] && (5*h_g[1] + k < cur_num_in);
        e[k][0] = live ? act_byte : 8'h00;
        e[k][1] = live ? wgt_byte : 8'h00;
      end
      check("ops", {op_e, op_d, op_c, op_b, op_a}, e);
      check("no_overlap", rd_en & res_valid, 1'b0);

      h_rd[1] = h_rd[0]; h_g[1] = h_g[0];
      h_rd[0] = rd_en;   h_g[0] = rd_in_neuron;
      if (rd_en) begin
        check("act_addr", act_addr, rd_in_neuron);
        check("wgt_addr", wgt_addr, wgt_exp);
        check("read_in_range", rd_in_neuron < (cur_num_in + 4) / 5, 1'b1);
        wgt_log.push_back(int'(wgt_addr));
        rd_cnt++; rd_in_neuron++; wgt_exp++;
      end

      if (res_valid) begin
        check("res_data", res_data, model_res());
        check("res_idx", res_idx, exp_idx);
        check("busy_while_valid", busy, 1'b1);
`ifdef FCL1_SCHED_BIAS_EN
        check("bias_addr", bias_addr, exp_idx);
`endif
        if (prev_stall) check("stall_stable", {res_data, res_idx}, {prev_data, prev_idx});
        prev_stall = !res_ready;
        prev_data  = res_data;
        prev_idx   = res_idx;
        if (res_ready) begin
          res_log.push_back(res_data);
          exp_idx++; acc_cnt++; rd_in_neuron = 0;
        end
      end else begin
        prev_stall = 1'b0;
      end

      if (done) begin
        done_cnt++;
        check("done_after_all", acc_cnt, cur_num_out);
        check("done_reads", rd_cnt, cur_num_out * ((cur_num_in + 4) / 5));
        check("done_busy_low", busy, 1'b0);
        acc_cnt = 0; rd_cnt = 0; exp_idx = 0; rd_in_neuron = 0; wgt_exp = 0;
      end
    end
  end

  // Runs one job; first_valid/done_at count posedges after start is driven.
  task automatic run_job(input int ni, input int no, input logic [7:0] a, input logic [7:0] w,
                         input int stall_idx, input int stall_n, input int ghost_at,
                         output int first_valid, output int done_at);
    int n, d0, stall_left;
    cur_num_in = ni; cur_num_out = no; act_byte = a; wgt_byte = w;
    res_log.delete(); wgt_log.delete();
    d0 = done_cnt; stall_left = stall_n; first_valid = -1; done_at = -1;
    @(posedge clk); #1;
    num_in = NUM_IN_W'(ni); num_out = NUM_OUT_W'(no); start = 1'b1;
    n = 0;
    while (done_at < 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
      start = (n == ghost_at);
      if (n == ghost_at) begin
        num_in = NUM_IN_W'(10); num_out = NUM_OUT_W'(1);
      end
      if (res_valid && first_valid < 0) first_valid = n;
      if (done && done_at < 0) done_at = n;
      if (res_valid && res_idx == stall_idx && stall_left > 0) begin
        res_ready = 1'b0; stall_left--;
      end else begin
        res_ready = res_valid;
      end
    end
    res_ready = 1'b0; start = 1'b0;
    if (done_at < 0) check("job_timeout", 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("done_once", done_cnt - d0, 1);
  endtask

  int fv, da, n;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl", {busy, done, rd_en, res_valid, act_addr, wgt_addr, res_idx, res_data}, '0);
    check("reset_ops", {op_e, op_d, op_c, op_b, op_a}, '0);
    rst_b = 1'b1;
    repeat (2) @(posedge clk);

    // Two full groups, latency from ISSUE entry.
    run_job(10, 1, 8'hcc, 8'hcc, -1, 0, -1, fv, da);
    check("t1_latency", fv - 1, 2 + 2 + MAC_LAT + 1);
    check("t1_result", res_log.size() > 0 ? res_log[0] : '1, ACC_W'(416160 + BIAS_TERM));

    // Partial last group.
    run_job(7, 1, 8'haa, 8'h01, -1, 0, -1, fv, da);
    check("t2_result", res_log.size() > 0 ? res_log[0] : '1, ACC_W'(1190 + BIAS_TERM));

    // Three neurons, neuron 1 stalled for 4 cycles.
    run_job(5, 3, 8'h02, 8'h05, 1, 4, -1, fv, da);
    check("t3_wgt_count", wgt_log.size(), 3);
    check("t3_wgt_seq", {wgt_log.size() > 2 ? wgt_log[2] : -1, wgt_log.size() > 1 ? wgt_log[1] : -1,
                         wgt_log.size() > 0 ? wgt_log[0] : -1}, {32'd2, 32'd1, 32'd0});
    check("t3_results", res_log.size(), 3);

    // No neurons: done two cycles after start, no reads.
    run_job(5, 0, 8'h11, 8'h22, -1, 0, -1, fv, da);
    check("t4_done_lat", da, 2);
    check("t4_no_reads", wgt_log.size(), 0);

    // No inputs: results are zero (or the bias).
    run_job(0, 2, 8'h33, 8'h44, -1, 0, -1, fv, da);
    check("t4b_count", res_log.size(), 2);
    check("t4b_res1", res_log.size() > 1 ? res_log[1] : '1, ACC_W'(BIAS_TERM));

    // Start pulse while busy must not change the job.
    run_job(5, 2, 8'h03, 8'h03, -1, 0, 3, fv, da);
    check("t6_ghost_count", res_log.size(), 2);
    check("t6_ghost_res", res_log.size() > 1 ? res_log[1] : '1, ACC_W'(45 + BIAS_TERM));

`ifdef FCL1_SCHED_BIAS_EN
    run_job(5, 1, 8'h01, 8'h01, -1, 0, -1, fv, da);
    check("t6_bias", res_log.size() > 0 ? res_log[0] : '1, ACC_W'(21));
`endif

    // Reset during ISSUE of neuron 1.
    cur_num_in = 10; cur_num_out = 3; act_byte = 8'h02; wgt_byte = 8'h03;
    @(posedge clk); #1;
    num_in = NUM_IN_W'(10); num_out = NUM_OUT_W'(3); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(rd_en && res_idx == 1) && n < 500) begin
      res_ready = res_valid;
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) check("t5_wait_timeout", 1'b1, 1'b0);
    fv = done_cnt;
    #2 rst_b = 1'b0;
    #1;
    check("t5_async_ctrl", {busy, done, rd_en, res_valid, act_addr, wgt_addr, res_idx, res_data}, '0);
    check("t5_async_ops", {op_e, op_d, op_c, op_b, op_a}, '0);
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("t5_no_done", done_cnt - fv, 0);
    run_job(5, 2, 8'h01, 8'h01, -1, 0, -1, fv, da);
    check("t5_clean_wgt0", wgt_log.size() > 0 ? wgt_log[0] : -1, 0);
    check("t5_clean_count", res_log.size(), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
